// File: rtl/serial_twos_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_twos_deserializer
// Brief    : LSB-first serial-to-parallel word assembler with optional
//            on-the-fly two's-complement negation and overflow/abort flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_twos_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             i,
    input  logic             i_valid,
    input  logic             sof,
    input  logic             neg,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             ovf,
    output logic             frame_err
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_seen_one;
    logic               r_neg_q;
    logic [WIDTH-1:0]   r_shreg;

    logic               w_out_bit;
    logic [WIDTH-1:0]   w_word;
    logic               w_last;

    // Serial negation: copy through the first 1, invert everything after it.
    always_comb begin
        w_out_bit = (r_neg_q & r_seen_one) ? ~i : i;
        w_word    = r_shreg | ({{(WIDTH-1){1'b0}}, w_out_bit} << r_cnt);
        w_last    = (r_cnt == c_last);
    end

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_neg_q    <= 1'b0;
            r_shreg    <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            ovf        <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            y_valid   <= 1'b0;
            frame_err <= 1'b0;
            if (i_valid) begin
                if (sof) begin
                    // A sof while a word is in flight aborts it; the bit still starts a new frame.
                    frame_err  <= (r_state == SHIFT);
                    r_state    <= SHIFT;
                    r_neg_q    <= neg;
                    r_seen_one <= i;
                    r_shreg    <= {{(WIDTH-1){1'b0}}, i};
                    r_cnt      <= c_one;
                end else if (r_state == SHIFT) begin
                    if (w_last) begin
                        y          <= w_word;
                        y_valid    <= 1'b1;
                        ovf        <= r_neg_q & ~r_seen_one & i;
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_shreg    <= '0;
                    end else begin
                        r_shreg    <= w_word;
                        r_cnt      <= r_cnt + c_one;
                        r_seen_one <= r_seen_one | i;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_twos_deserializer
// Brief    : Scoreboard bench for serial_twos_deserializer (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_twos_deserializer;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             ovf;
    } exp_t;

    logic             t_clk = 1'b0;
    logic             r     = 1'b1;
    logic             i     = 1'b0;
    logic             i_valid = 1'b0;
    logic             sof   = 1'b0;
    logic             neg   = 1'b0;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             ovf;
    logic             frame_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ferr_expected = 0;
    int   ferr_seen     = 0;
    exp_t             exp_q[$];
    int               yv_cycles[$];
    logic [WIDTH-1:0] last_y = '0;
    logic             prev_yv = 1'b0;

    serial_twos_deserializer #(.WIDTH(WIDTH)) dut (
        .t_clk     (t_clk),
        .r         (r),
        .i         (i),
        .i_valid   (i_valid),
        .sof       (sof),
        .neg       (neg),
        .y         (y),
        .y_valid   (y_valid),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    always #5 t_clk = ~t_clk;
    always @(posedge t_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: negation as plain modular arithmetic.
    task automatic push_expect(input logic [WIDTH-1:0] val, input logic negv);
        exp_t e;
        e.y   = negv ? WIDTH'(~val + 1'b1) : val;
        e.ovf = negv && (val == {1'b1, {(WIDTH-1){1'b0}}});
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] val, input logic negv,
                             input int nbits, input int maxgap);
        for (int k = 0; k < nbits; k++) begin
            @(negedge t_clk);
            i_valid = 1'b1;
            i       = val[k];
            sof     = (k == 0);
            neg     = negv;
            if (maxgap > 0 && k < nbits - 1) begin
                int gaps;
                gaps = $urandom_range(maxgap, 0);
                for (int g = 0; g < gaps; g++) begin
                    @(negedge t_clk);
                    i_valid = 1'b0;
                    i       = 1'($urandom);
                    sof     = 1'($urandom);
                    neg     = 1'($urandom);
                end
            end
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] val, input logic negv, input int maxgap);
        push_expect(val, negv);
        send_bits(val, negv, WIDTH, maxgap);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge t_clk);
            i_valid = 1'b0;
            sof     = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 40) begin
            @(negedge t_clk);
            budget++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge t_clk) begin
        if (!r) begin
            if (y_valid || frame_err)
                check("yv_ferr_exclusive", {31'd0, y_valid & frame_err}, 0);
            if (y_valid) begin
                check("yv_one_cycle", {31'd0, prev_yv}, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_y_valid", {24'd0, y}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("y", {24'd0, y}, {24'd0, e.y});
                    check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                end
                last_y = y;
                yv_cycles.push_back(cyc);
            end
            if (frame_err) begin
                ferr_seen++;
                check("y_hold_on_abort", {24'd0, y}, {24'd0, last_y});
            end
            prev_yv = y_valid;
        end else begin
            prev_yv = 1'b0;
        end
    end

    initial begin
        repeat (3) @(negedge t_clk);
        check("rst_y", {24'd0, y}, 0);
        check("rst_y_valid", {31'd0, y_valid}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        r = 1'b0;
        idle(2);

        send_word(8'h05, 1'b1, 0);
        send_word(8'h80, 1'b1, 0);
        send_word(8'h00, 1'b1, 0);
        send_word(8'h80, 1'b0, 0);
        idle(2);
        drain();

        send_word(8'h3C, 1'b0, 3);
        idle(6);
        drain();
        check("y_hold_3c", {24'd0, y}, 32'h3C);

        // Abort: three bits then a fresh sof carrying 0x01.
        send_bits(8'hA5, 1'b1, 3, 0);
        ferr_expected++;
        send_word(8'h01, 1'b1, 0);
        idle(3);
        drain();

        // Asynchronous reset in mid-word.
        send_bits(8'h5A, 1'b1, 4, 0);
        @(posedge t_clk);
        #2;
        i_valid = 1'b0;
        r = 1'b1;
        #1;
        check("arst_y", {24'd0, y}, 0);
        check("arst_flags", {29'd0, y_valid, ovf, frame_err}, 0);
        @(negedge t_clk);
        r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge t_clk);
            i_valid = 1'b1;
            i       = 1'b1;
            sof     = 1'b0;
            neg     = 1'b1;
        end
        idle(2);
        check("stray_ignored", {24'd0, y}, 0);
        send_word(8'h02, 1'b1, 0);
        idle(3);
        drain();

        // Back-to-back words.
        yv_cycles.delete();
        send_word(8'h01, 1'b1, 0);
        send_word(8'h7F, 1'b1, 0);
        idle(3);
        drain();
        check("b2b_count", yv_cycles.size(), 2);
        if (yv_cycles.size() == 2)
            check("b2b_spacing", yv_cycles[1] - yv_cycles[0], WIDTH);

        idle(2);
        check("frame_err_count", ferr_seen, ferr_expected);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_twos_deserializer.md
Name: serial_twos_deserializer

Overview:
- Receive-side counterpart to the bit-serial two's-complement converter. Takes an LSB-first serial bit stream framed into WIDTH-bit words.
- Optionally applies serial two's-complement negation on the fly: bits pass unchanged up to and including the first 1, and every later bit is inverted.
- Assembles each word into a parallel register and presents it with a one-cycle valid strobe.
- Sits after the serial link and returns the serial domain to word-parallel datapath logic.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- t_clk  input  1  system clock; all state updates on rising edge.
- r  input  1  reset; asynchronous, active-high; clears all state and outputs.
- i  input  1  serial data bit, LSB first.
- i_valid  input  1  qualifies i; one bit is consumed per cycle with i_valid=1.
- sof  input  1  start of frame; meaningful only with i_valid=1; marks i as bit 0.
- neg  input  1  sampled with the sof bit; 1 = negate word, 0 = pass through.
- y  output  WIDTH  last completed word; holds until the next word completes.
- y_valid  output  1  one-cycle pulse when y updates.
- ovf  output  1  valid with y_valid; 1 = negation overflow (input was the most-negative value).
- frame_err  output  1  one-cycle pulse when a frame is aborted by an early sof.

Behaviour:
- Reset (r=1, asynchronous): state=IDLE, bit counter=0, seen_one=0, neg_q=0, shift register=0, y=0, y_valid=0, ovf=0, frame_err=0.
- Reset mid-word discards the partial word. No y_valid is produced for it.
- States: IDLE and SHIFT.
  - IDLE: i_valid=1 and sof=0 → bit dropped, stay IDLE.
  - IDLE: i_valid=1 and sof=1 → accept bit 0, latch neg_q=neg, count=1, go to SHIFT.
  - SHIFT: i_valid=1 and sof=0 → accept next bit, count+1.
  - SHIFT: i_valid=0 → hold all state; gaps of any length are allowed.
- Per accepted bit b:
  - out_b = (neg_q & seen_one) ? ~b : b.
  - Then seen_one |= b.
  - For the bit-0 cycle, neg_q and seen_one are the freshly loaded values (neg, 0).
  - out_b is written into shift position count (LSB first).
- Word completion: the cycle that accepts bit WIDTH-1 registers y = assembled word, y_valid=1 for exactly the following cycle, and returns state to IDLE.
- Latency: y/y_valid appear 1 cycle after the last bit's clock edge.
- ovf:
  - Set to 1 when neg_q=1, seen_one was 0 before bit WIDTH-1, and bit WIDTH-1 = 1 (input 100..0). In that case y = 100..0.
  - ovf=0 in all other cases, including pass-through mode and zero input.
  - ovf updates only together with y_valid and holds its value otherwise.
- Zero word with neg=1 → y=0, ovf=0.
- Early sof: sof & i_valid in SHIFT before bit WIDTH-1 is accepted:
  - frame_err pulses 1 cycle later.
  - The partial word is discarded; no y_valid, and y keeps its old value.
  - The sof bit is accepted as bit 0 of a new frame, with neg re-latched and seen_one reset.
- sof coincident with what would be bit WIDTH-1 counts as an early sof. It raises frame_err and starts a new frame.
- Back-to-back frames: sof may arrive the cycle after the last bit. y_valid for the old word then coincides with acceptance of the new bit 0, and both must work.
- Counter width: clog2(WIDTH+1). No wrap occurs because the counter returns to 0 on completion or abort.
- y_valid and frame_err are never asserted in the same cycle.

Test Plan:
- WIDTH=8, neg=1, send 0x05 LSB first (1,0,1,0,0,0,0,0) with sof on the first bit → y=0xFB, y_valid high 1 cycle, ovf=0.
- neg=1, send 0x80 → y=0x80, ovf=1. Then send 0x00 → y=0x00, ovf=0.
- neg=0, send 0x3C with random i_valid gaps (0–3 idle cycles between bits) → y=0x3C, ovf=0. y holds 0x3C afterward until the next completion.
- neg=1, 3 bits of a frame, then sof with word 0x01 → frame_err pulse 1 cycle, no y_valid for the aborted frame, then y=0xFF.
- neg=1, assert r asynchronously (mid-cycle) after 4 bits → y=0 and flags 0 immediately. Then send 0x02 → y=0xFE; stray bits without sof in IDLE are ignored.
- Back-to-back 0x01 then 0x7F (neg=1) with no gap → two y_valid pulses exactly 8 cycles apart, y=0xFF then y=0x81, no frame_err.
